// File: rtl/dmem_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_stall_ctrl_if
// Groups the pipeline-side request/response signals and the backing data-bus
// handshake of the MEM-stage data-memory controller.
//   Pipeline side : mem_read_i, mem_write_i, addr_i, wdata_i  (to controller)
//                   rdata_o, stall_o, err_o                   (from controller)
//   Bus side      : bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o (from controller)
//                   bus_rdata_i, bus_ack_i                       (to controller)
// Modports:
//   master : the controller itself (it masters the backing bus)
//   slave  : the environment (pipeline register + bus target)
// -----------------------------------------------------------------------------
interface dmem_stall_ctrl_if;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;

  modport master (
    input  mem_read_i, mem_write_i, addr_i, wdata_i, bus_rdata_i, bus_ack_i,
    output rdata_o, stall_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

  modport slave (
    output mem_read_i, mem_write_i, addr_i, wdata_i, bus_rdata_i, bus_ack_i,
    input  rdata_o, stall_o, err_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_stall_ctrl
// MEM-stage data-memory controller. Turns single-cycle load/store requests into
// multi-cycle bus transactions, freezing the pipeline until each completes.
// A one-entry write-through read-hit buffer lets repeated loads of the same
// word complete without a bus access. A transaction that receives no ack
// within TIMEOUT bus cycles is aborted and reported on err_o.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   dif    : dmem_stall_ctrl_if.master (pipeline request/response + bus)
// Parameters:
//   TIMEOUT    : bus cycles without ack before abort (2..255)
//   HIT_BUF_EN : 1 enables the one-entry read-hit buffer
// -----------------------------------------------------------------------------
module dmem_stall_ctrl #(
  parameter int TIMEOUT    = 16,
  parameter bit HIT_BUF_EN = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  dmem_stall_ctrl_if.master      dif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_tmo;
  logic        r_buf_vld;
  logic [29:0] r_buf_tag;
  logic [31:0] r_buf_data;

  logic        w_req;
  logic        w_misalign;
  logic        w_conflict;
  logic        w_hit;
  logic        w_start;
  logic        w_stall;
  logic        w_err;
  logic [31:0] w_rdata;

  assign w_req      = dif.mem_read_i | dif.mem_write_i;
  assign w_misalign = w_req & (dif.addr_i[1:0] != 2'b00);
  assign w_conflict = dif.mem_read_i & dif.mem_write_i;
  // A hit needs a pure, aligned load whose word matches the buffered one.
  assign w_hit      = HIT_BUF_EN && r_buf_vld && (r_buf_tag == dif.addr_i[31:2]) &&
                      dif.mem_read_i && !dif.mem_write_i && !w_misalign;
  assign w_start    = (r_state == S_IDLE) & w_req & ~w_misalign & ~w_hit;

  // Pipeline-facing response: stall, error pulse and load data per state.
  always_comb begin
    w_stall = 1'b0;
    w_err   = 1'b0;
    w_rdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_misalign) begin
            w_err = 1'b1;
          end else if (w_hit) begin
            w_rdata = r_buf_data;
          end else begin
            // Read+write together proceeds as a store but is still flagged.
            w_stall = 1'b1;
            w_err   = w_conflict;
          end
        end else begin
          w_stall = 1'b0;
        end
      end
      S_BUS: begin
        w_stall = 1'b1;
      end
      S_DONE: begin
        // r_tmo marks an aborted transaction; its error shows here, one
        // cycle after the abort decision.
        w_rdata = r_rdata;
        w_err   = r_tmo;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  assign dif.stall_o     = w_stall;
  assign dif.err_o       = w_err;
  assign dif.rdata_o     = w_rdata;
  assign dif.bus_req_o   = r_req;
  assign dif.bus_we_o    = r_we;
  assign dif.bus_addr_o  = r_addr;
  assign dif.bus_wdata_o = r_wdata;

  // Controller FSM, bus request registers, timeout counter and hit buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_tmo      <= 1'b0;
      r_buf_vld  <= 1'b0;
      r_buf_tag  <= 30'd0;
      r_buf_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= dif.mem_write_i;
            r_addr  <= {dif.addr_i[31:2], 2'b00};
            r_wdata <= dif.wdata_i;
            r_cnt   <= 8'd0;
            r_tmo   <= 1'b0;
            r_state <= S_BUS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUS: begin
          if (dif.bus_ack_i) begin
            r_req   <= 1'b0;
            r_tmo   <= 1'b0;
            r_rdata <= r_we ? 32'd0 : dif.bus_rdata_i;
            r_state <= S_DONE;
            if (HIT_BUF_EN) begin
              if (!r_we) begin
                r_buf_vld  <= 1'b1;
                r_buf_tag  <= r_addr[31:2];
                r_buf_data <= dif.bus_rdata_i;
              end else if (r_buf_vld && (r_buf_tag == r_addr[31:2])) begin
                // Write-through keeps the buffered word coherent with memory.
                r_buf_data <= r_wdata;
              end else begin
                r_buf_vld <= r_buf_vld;
              end
            end else begin
              r_buf_vld <= 1'b0;
            end
          end else if (r_cnt == TMO_LAST) begin
            // Abort: memory state is unknown, so drop the buffered word too.
            r_req     <= 1'b0;
            r_tmo     <= 1'b1;
            r_rdata   <= 32'd0;
            r_buf_vld <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          // Same instruction is still on the inputs here; never re-issue it.
          r_tmo   <= 1'b0;
          r_rdata <= 32'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_stall_ctrl
// Self-checking bench for dmem_stall_ctrl. Each memory instruction pushes its
// expected outcome to a scoreboard queue; the entry is popped and compared
// when the controller releases the stall for that instruction.
// -----------------------------------------------------------------------------
module tb_dmem_stall_ctrl;

  logic clk;
  logic rst;

  dmem_stall_ctrl_if dif();

  dmem_stall_ctrl #(
    .TIMEOUT    (16),
    .HIT_BUF_EN (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    int          stalls;
    int          errs;
    bit          bus;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          ack_delay = 0;
  int          bus_cnt   = 0;
  bit          force_ack = 1'b0;
  logic [31:0] resp_data = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Bus target: acks in BUS cycle index ack_delay-1 (0 = never acks).
  task automatic bus_respond();
    if (force_ack) begin
      dif.bus_ack_i   = 1'b1;
      dif.bus_rdata_i = resp_data;
    end else if (dif.bus_req_o) begin
      dif.bus_ack_i   = (ack_delay > 0) && (bus_cnt == ack_delay - 1);
      dif.bus_rdata_i = dif.bus_ack_i ? resp_data : 32'd0;
      bus_cnt++;
    end else begin
      dif.bus_ack_i   = 1'b0;
      dif.bus_rdata_i = 32'd0;
      bus_cnt         = 0;
    end
  endtask

  task automatic do_access(input string tag, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int dly, input logic [31:0] resp,
                           input logic [31:0] exp_rdata, input int exp_stalls,
                           input int exp_errs, input bit exp_bus);
    exp_t e;
    int   stalls = 0;
    int   errs   = 0;
    bit   seen   = 1'b0;
    bit   done   = 1'b0;
    logic        s_we    = 1'b0;
    logic [31:0] s_addr  = 32'd0;
    logic [31:0] s_wdata = 32'd0;
    logic        req_end = 1'b0;
    logic [31:0] rd_end  = 32'd0;
    e.tag = tag; e.rdata = exp_rdata; e.stalls = exp_stalls; e.errs = exp_errs;
    e.bus = exp_bus; e.we = wr; e.addr = {addr[31:2], 2'b00}; e.wdata = wdata;
    sb_q.push_back(e);
    ack_delay = dly;
    resp_data = resp;
    @(negedge clk);
    dif.mem_read_i  = rd;
    dif.mem_write_i = wr;
    dif.addr_i      = addr;
    dif.wdata_i     = wdata;
    for (int c = 0; c < 200; c++) begin
      bus_respond();
      #1;
      if (dif.err_o) errs++;
      if (dif.bus_req_o && !seen) begin
        seen    = 1'b1;
        s_we    = dif.bus_we_o;
        s_addr  = dif.bus_addr_o;
        s_wdata = dif.bus_wdata_o;
      end
      if (!dif.stall_o) begin
        done    = 1'b1;
        req_end = dif.bus_req_o;
        rd_end  = dif.rdata_o;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    e = sb_q.pop_front();
    if (!done) begin
      check_eq({e.tag, "_no_completion"}, 32'd0, 32'd1);
    end else begin
      check_eq({e.tag, "_rdata"}, rd_end, e.rdata);
      check_eq({e.tag, "_stalls"}, 32'(stalls), 32'(e.stalls));
      check_eq({e.tag, "_errs"}, 32'(errs), 32'(e.errs));
      check_eq({e.tag, "_bus_used"}, {31'd0, seen}, {31'd0, e.bus});
      check_eq({e.tag, "_req_at_end"}, {31'd0, req_end}, 32'd0);
      if (e.bus) begin
        check_eq({e.tag, "_bus_we"}, {31'd0, s_we}, {31'd0, e.we});
        check_eq({e.tag, "_bus_addr"}, s_addr, e.addr);
        if (e.we) check_eq({e.tag, "_bus_wdata"}, s_wdata, e.wdata);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_stall"}, {31'd0, dif.stall_o}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, dif.err_o}, 32'd0);
    check_eq({tag, "_rdata"}, dif.rdata_o, 32'd0);
    check_eq({tag, "_bus_req"}, {31'd0, dif.bus_req_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    dif.mem_read_i  = 1'b0;
    dif.mem_write_i = 1'b0;
    dif.addr_i      = 32'd0;
    dif.wdata_i     = 32'd0;
    dif.bus_ack_i   = 1'b0;
    dif.bus_rdata_i = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: everything quiet.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_respond();
      #1;
      check_idle("reset_idle");
      check_eq("reset_bus_addr", dif.bus_addr_o, 32'd0);
      check_eq("reset_bus_we", {31'd0, dif.bus_we_o}, 32'd0);
    end

    // Miss, ack in third bus cycle -> 4 stall cycles.
    do_access("ld40_miss", 1'b1, 1'b0, 32'h40, 32'd0, 3, 32'hDEADBEEF,
              32'hDEADBEEF, 4, 0, 1'b1);
    // Same word again hits with no stall.
    do_access("ld40_hit", 1'b1, 1'b0, 32'h40, 32'd0, 1, 32'hFFFFFFFF,
              32'hDEADBEEF, 0, 0, 1'b0);
    // Store writes through to the buffer.
    do_access("st40", 1'b0, 1'b1, 32'h40, 32'h12345678, 1, 32'hFFFFFFFF,
              32'd0, 2, 0, 1'b1);
    do_access("ld40_hit_wt", 1'b1, 1'b0, 32'h40, 32'd0, 1, 32'hFFFFFFFF,
              32'h12345678, 0, 0, 1'b0);
    // Misaligned load.
    do_access("ld43_misalign", 1'b1, 1'b0, 32'h43, 32'd0, 1, 32'hFFFFFFFF,
              32'd0, 0, 1, 1'b0);
    // No ack: 1 request cycle + 16 bus cycles stalled, error in DONE.
    do_access("ld80_timeout", 1'b1, 1'b0, 32'h80, 32'd0, 0, 32'hFFFFFFFF,
              32'd0, 17, 1, 1'b1);
    // Buffer was invalidated by the abort.
    do_access("ld40_after_tmo", 1'b1, 1'b0, 32'h40, 32'd0, 1, 32'hCAFEF00D,
              32'hCAFEF00D, 2, 0, 1'b1);
    // Read+write conflict to another word: store, flagged, buffer untouched.
    do_access("rw44_conflict", 1'b1, 1'b1, 32'h44, 32'h0F0F0F0F, 1, 32'hFFFFFFFF,
              32'd0, 2, 1, 1'b1);
    do_access("ld40_hit_keep", 1'b1, 1'b0, 32'h40, 32'd0, 1, 32'hFFFFFFFF,
              32'hCAFEF00D, 0, 0, 1'b0);

    // Reset in the second bus cycle, then a late ack.
    ack_delay = 0;
    @(negedge clk);
    dif.mem_read_i  = 1'b1;
    dif.mem_write_i = 1'b0;
    dif.addr_i      = 32'h100;
    bus_respond();
    #1;
    check_eq("rst_req_stall", {31'd0, dif.stall_o}, 32'd1);
    @(negedge clk);
    bus_respond();
    #1;
    check_eq("rst_bus1_req", {31'd0, dif.bus_req_o}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    bus_respond();
    #1;
    @(negedge clk);
    rst             = 1'b0;
    dif.mem_read_i  = 1'b0;
    dif.addr_i      = 32'd0;
    force_ack       = 1'b1;
    resp_data       = 32'h55AA55AA;
    bus_respond();
    #1;
    check_idle("rst_after");
    @(negedge clk);
    force_ack = 1'b0;
    bus_respond();
    #1;
    check_idle("rst_late_ack");
    do_access("ld40_after_rst", 1'b1, 1'b0, 32'h40, 32'd0, 1, 32'h0BADF00D,
              32'h0BADF00D, 2, 0, 1'b1);

    @(negedge clk);
    dif.mem_read_i  = 1'b0;
    dif.mem_write_i = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- MEM-stage data-memory controller between the EX/MEM pipeline register and a multi-cycle backing data bus.
- Converts single-cycle MemRead/MemWrite requests into bus transactions and stalls the pipeline until each completes.
- Provides a one-entry read-hit buffer (write-through) and a bus timeout.
- Its read data feeds the MEM/WB register in place of a zero-latency data memory.

Parameters:
- TIMEOUT, 16: max cycles in BUS state without bus_ack_i before abort; legal range 2..255.
- HIT_BUF_EN, 1: 1 = one-entry read-hit buffer enabled; 0 = every access goes to the bus.

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- mem_read_i  in  1  load request from EX/MEM M field
- mem_write_i  in  1  store request from EX/MEM M field
- addr_i  in  32  byte address (EX/MEM ALU result)
- wdata_i  in  32  store data (EX/MEM forwarded RT value)
- rdata_o  out  32  load data, valid when load completes (stall_o=0)
- stall_o  out  1  pipeline hold: PC, IF/ID, ID/EX, EX/MEM freeze; MEM/WB takes a bubble
- err_o  out  1  one-cycle pulse: misaligned access, read+write conflict, or timeout
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  1 = write transaction, registered
- bus_addr_o  out  32  word-aligned bus address, registered
- bus_wdata_o  out  32  bus write data, registered
- bus_rdata_i  in  32  bus read data, sampled when bus_ack_i=1
- bus_ack_i  in  1  one-cycle transaction complete

Behaviour:
- Reset (rst_i=1 at clock edge): state=IDLE; all outputs 0; hit buffer invalid; timeout counter 0. Applies mid-transaction: bus_req_o low the following cycle; a late ack is ignored.
- States: IDLE, BUS, DONE.
- Request: req = mem_read_i | mem_write_i, evaluated only in IDLE.
- IDLE, no req: stall_o=0, rdata_o=0.
- IDLE, misaligned (addr_i[1:0]!=0):
  - no bus access; err_o=1 this cycle (combinational); stall_o=0; rdata_o=0; stay IDLE.
- IDLE, read hit (HIT_BUF_EN, buffer valid, tag==addr_i[31:2], mem_write_i=0):
  - stall_o=0; rdata_o=buffer data combinationally; no bus access; stay IDLE.
- IDLE, other req:
  - stall_o=1 combinationally.
  - Register bus_req_o=1, bus_we_o=mem_write_i, bus_addr_o={addr_i[31:2],2'b00}, bus_wdata_o=wdata_i.
  - Go to BUS; timeout counter=0.
- Read and write both high: treated as write; err_o pulses in the IDLE cycle.
- BUS:
  - stall_o=1; bus_* held stable.
  - bus_ack_i=1: capture bus_rdata_i (reads); drop bus_req_o; go DONE.
  - Read completion fills the buffer (tag, data, valid=1).
  - Write completion with tag match updates buffer data (write-through); non-matching write leaves buffer unchanged.
  - No ack: counter++. At counter==TIMEOUT-1 without ack: drop bus_req_o, err_o pulse next cycle, captured data=0, invalidate buffer, go DONE.
- DONE:
  - stall_o=0; rdata_o=captured data for reads, 0 for writes.
  - Pipeline advances at the end of this cycle.
  - Request inputs are ignored (same instruction still present); unconditional return to IDLE.
- Latency: miss with ack one cycle after request = request cycle + BUS cycle stalled, data in DONE (2 stall cycles). Hit = 0 stall cycles.
- bus_req_o is never asserted in IDLE or DONE; at most one outstanding transaction.
- err_o never asserted together with a bus_req_o rise.

Test Plan:
- Reset, then idle with no requests -> all outputs 0, stall_o=0 for 10 cycles.
- Load addr 0x40, ack 3 cycles after bus_req_o rises with rdata 0xDEADBEEF -> stall_o high 4 cycles; DONE cycle rdata_o=0xDEADBEEF, stall_o=0; bus_req_o low after ack.
- Repeat load 0x40 next instruction -> stall_o=0, rdata_o=0xDEADBEEF same cycle, bus_req_o stays 0.
- Store 0x12345678 to 0x40 (ack after 1 cycle), then load 0x40 -> store stalls 2 cycles, bus_we_o=1, bus_wdata_o=0x12345678; the following load hits with 0x12345678.
- Load 0x43 -> err_o=1 for one cycle, no bus_req_o, stall_o=0. Load 0x80 with no ack -> abort after TIMEOUT(16) BUS cycles, err_o pulse, rdata_o=0, buffer invalid (next load 0x40 misses).
- rst_i asserted in second BUS cycle, ack arrives afterwards -> bus_req_o=0 next cycle, state IDLE, ack ignored, buffer invalid.
